// File: rtl/t1_linebuf_unrolled_4.sv
// ---------------------------------------------------------------------------
// t1_linebuf_unrolled_4
// Three-row line buffer for a 4-pixel-wide stencil stage. Input beats carry
// four adjacent pixels of one row. Two row buffers hold the two previous rows.
// Once row r >= 2 is streaming, every accepted beat produces one window:
//   top = row r-1 ... no, top = row y-1, mid = row y (6 pixels incl. halo),
//   bot = row y+1, where y = r-1 and the group g is taken from the beat.
// The halo pixels are replicated at the left and right image edges.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle pulse, begins a frame (ignored unless idle)
//   in_valid/in_ready   input beat handshake, in_data = 4 pixels of one row
//   out_valid/out_ready window handshake
//   out_top/out_bot     4 pixels of rows y-1 / y+1 at x = 4g..4g+3
//   out_mid             6 pixels of row y at x = 4g-1..4g+4 (lane 0 = 4g-1)
//   out_y, out_g        centre row and group of the current window
//   done                one-cycle pulse after the last window is taken
// ---------------------------------------------------------------------------
module t1_linebuf_unrolled_4 #(
  parameter int DW    = 16,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4*DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4*DW-1:0] out_top,
  output logic [6*DW-1:0] out_mid,
  output logic [4*DW-1:0] out_bot,
  output logic [15:0]   out_y,
  output logic [15:0]   out_g,
  output logic          done
);

  localparam int G  = IMG_W / 4;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam logic [GW-1:0] LAST_G    = GW'(G - 1);
  localparam logic [15:0]   LAST_G16  = 16'(G - 1);
  localparam logic [15:0]   ROWS16    = 16'(IMG_H);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t             r_state;
  logic [15:0]        r_row;
  logic [15:0]        r_grp;
  logic               r_newSel;
  logic               r_outValid;
  logic [4*DW-1:0]    r_outTop;
  logic [6*DW-1:0]    r_outMid;
  logic [4*DW-1:0]    r_outBot;
  logic [15:0]        r_outY;
  logic [15:0]        r_outG;
  logic               r_done;

  logic [4*DW-1:0]    r_buf0 [G];
  logic [4*DW-1:0]    r_buf1 [G];

  logic               w_accept;
  logic               w_rowEnd;
  logic [GW-1:0]      w_gIdx;
  logic [GW-1:0]      w_gPrev;
  logic [GW-1:0]      w_gNext;
  logic [4*DW-1:0]    w_top;
  logic [4*DW-1:0]    w_midCur;
  logic [4*DW-1:0]    w_midPrev;
  logic [4*DW-1:0]    w_midNext;
  logic [DW-1:0]      w_midLo;
  logic [DW-1:0]      w_midHi;

  // Beats are taken only while a frame is open, rows remain, and the window
  // register is free or being drained this cycle.
  assign in_ready = (r_state != IDLE) && (r_row != ROWS16) && (!r_outValid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_rowEnd = w_accept && (r_grp == LAST_G16);

  assign w_gIdx  = r_grp[GW-1:0];
  assign w_gPrev = (w_gIdx == '0)     ? '0     : w_gIdx - 1'b1;
  assign w_gNext = (w_gIdx == LAST_G) ? LAST_G : w_gIdx + 1'b1;

  // r_newSel marks which buffer holds row r-1; the other holds row r-2 and is
  // overwritten in place by row r, since each top entry is read on the same
  // edge it is replaced.
  assign w_top     = r_newSel ? r_buf0[w_gIdx]  : r_buf1[w_gIdx];
  assign w_midCur  = r_newSel ? r_buf1[w_gIdx]  : r_buf0[w_gIdx];
  assign w_midPrev = r_newSel ? r_buf1[w_gPrev] : r_buf0[w_gPrev];
  assign w_midNext = r_newSel ? r_buf1[w_gNext] : r_buf0[w_gNext];

  // Halo pixels: neighbouring groups inside the row, edge pixel replicated at
  // the image borders.
  assign w_midLo = (w_gIdx == '0)     ? w_midCur[DW-1:0]    : w_midPrev[3*DW +: DW];
  assign w_midHi = (w_gIdx == LAST_G) ? w_midCur[3*DW +: DW] : w_midNext[DW-1:0];

  // Row buffer storage, not reset: contents are always rewritten before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (r_newSel) r_buf0[w_gIdx] <= in_data;
      else          r_buf1[w_gIdx] <= in_data;
    end
  end

  // Frame control, counters and the registered window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_grp      <= '0;
      r_newSel   <= 1'b0;
      r_outValid <= 1'b0;
      r_outTop   <= '0;
      r_outMid   <= '0;
      r_outBot   <= '0;
      r_outY     <= '0;
      r_outG     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= FILL;
            r_row   <= '0;
            r_grp   <= '0;
          end
        end
        FILL, STREAM: begin
          if (w_accept) begin
            if (w_rowEnd) begin
              r_grp    <= '0;
              r_row    <= r_row + 16'd1;
              r_newSel <= ~r_newSel;
              if (r_row == 16'd1) r_state <= STREAM;
            end else begin
              r_grp <= r_grp + 16'd1;
            end
          end
          // All beats in and the final window is being taken: close the frame.
          if ((r_state == STREAM) && (r_row == ROWS16) && r_outValid && out_ready) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
            r_row   <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_accept && (r_state == STREAM)) begin
        r_outValid <= 1'b1;
        r_outTop   <= w_top;
        r_outMid   <= {w_midHi, w_midCur, w_midLo};
        r_outBot   <= in_data;
        r_outY     <= r_row - 16'd1;
        r_outG     <= r_grp;
      end else if (r_outValid && out_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign out_valid = r_outValid;
  assign out_top   = r_outTop;
  assign out_mid   = r_outMid;
  assign out_bot   = r_outBot;
  assign out_y     = r_outY;
  assign out_g     = r_outG;
  assign done      = r_done;

endmodule

// File: tb/tb_t1_linebuf_unrolled_4.sv
// ---------------------------------------------------------------------------
// tb_t1_linebuf_unrolled_4
// Self-checking bench for t1_linebuf_unrolled_4 with IMG_W=8, IMG_H=4.
// Each frame fills a pixel array (16y+x or random), derives the expected
// window list from it by clamped coordinates, then drives beats and checks
// every window handshake, hold-under-backpressure, done timing and resets.
// ---------------------------------------------------------------------------
module tb_t1_linebuf_unrolled_4;

  localparam int DW = 16;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int G  = W / 4;
  localparam int NB = H * G;
  localparam int NW = (H - 2) * G;

  logic            clk;
  logic            rst;
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic [4*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [4*DW-1:0] out_top;
  logic [6*DW-1:0] out_mid;
  logic [4*DW-1:0] out_bot;
  logic [15:0]     out_y;
  logic [15:0]     out_g;
  logic            done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4*DW-1:0] top;
    logic [6*DW-1:0] mid;
    logic [4*DW-1:0] bot;
    int              y;
    int              g;
  } win_t;

  logic [DW-1:0] pix [H][W];
  win_t          expQ [$];

  t1_linebuf_unrolled_4 #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_top  (out_top),
    .out_mid  (out_mid),
    .out_bot  (out_bot),
    .out_y    (out_y),
    .out_g    (out_g),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*DW-1:0] beatData(input int idx);
    logic [4*DW-1:0] d;
    int row = idx / G;
    int grp = idx % G;
    for (int k = 0; k < 4; k++) d[k*DW +: DW] = pix[row][4*grp + k];
    return d;
  endfunction

  // Expected windows straight from the image: neighbours of each pixel with
  // x clamped into the image.
  task automatic buildFrame(input bit directed);
    win_t e;
    int   x;
    for (int y = 0; y < H; y++)
      for (int xx = 0; xx < W; xx++)
        pix[y][xx] = directed ? DW'(16 * y + xx) : DW'($urandom);
    expQ.delete();
    for (int y = 1; y <= H - 2; y++) begin
      for (int g = 0; g < G; g++) begin
        for (int k = 0; k < 4; k++) begin
          e.top[k*DW +: DW] = pix[y-1][4*g + k];
          e.bot[k*DW +: DW] = pix[y+1][4*g + k];
        end
        for (int j = 0; j < 6; j++) begin
          x = 4*g - 1 + j;
          if (x < 0) x = 0;
          if (x > W - 1) x = W - 1;
          e.mid[j*DW +: DW] = pix[y][x];
        end
        e.y = y;
        e.g = g;
        expQ.push_back(e);
      end
    end
  endtask

  // One frame. directed: fixed pixels, in_valid/out_ready high except one
  // 5-cycle stall. rstAfter>0: reset once that many beats are in. midStart:
  // pulse start while streaming.
  task automatic applyStimulus(input bit directed, input int rstAfter, input bit midStart);
    int              srcIdx  = 0;
    int              winCnt  = 0;
    int              bpHold  = 0;
    bit              bpUsed  = 1'b0;
    bit              expDone = 1'b0;
    bit              sawDone = 1'b0;
    bit              startedMid = 1'b0;
    bit              prevStall  = 1'b0;
    bit              wasReset   = 1'b0;
    logic [4*DW-1:0] prevTop;
    logic [6*DW-1:0] prevMid;
    logic [4*DW-1:0] prevBot;
    win_t            e;

    buildFrame(directed);
    @(posedge clk); #1;
    start     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;

      if (rstAfter > 0 && srcIdx == rstAfter) begin
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_out_mid", out_mid, '0);
        wasReset = 1'b1;
        break;
      end

      if (midStart && !startedMid && srcIdx == 2*G + 1) begin
        start      = 1'b1;
        startedMid = 1'b1;
      end
      in_valid = (srcIdx < NB) && (directed ? 1'b1 : ($urandom_range(0, 3) != 0));
      in_data  = in_valid ? beatData(srcIdx) : {$urandom, $urandom};
      if (bpHold > 0) begin
        out_ready = 1'b0;
        bpHold--;
      end else begin
        out_ready = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
      end

      @(negedge clk);
      checkOutput("done", done, expDone);
      expDone = 1'b0;
      if (done) begin
        sawDone = 1'b1;
        checkOutput("idle_in_ready", in_ready, 1'b0);
        checkOutput("idle_out_valid", out_valid, 1'b0);
        break;
      end

      if (prevStall) begin
        checkOutput("hold_valid", out_valid, 1'b1);
        checkOutput("hold_top", out_top, prevTop);
        checkOutput("hold_mid", out_mid, prevMid);
        checkOutput("hold_bot", out_bot, prevBot);
      end
      if (out_valid && !out_ready) checkOutput("bp_in_ready", in_ready, 1'b0);

      if (directed && out_valid && !bpUsed) begin
        bpUsed = 1'b1;
        bpHold = 5;
      end

      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("extra_window", 1'b1, 1'b0);
        end else begin
          e = expQ.pop_front();
          checkOutput("win_top", out_top, e.top);
          checkOutput("win_mid", out_mid, e.mid);
          checkOutput("win_bot", out_bot, e.bot);
          checkOutput("win_y", out_y, 16'(e.y));
          checkOutput("win_g", out_g, 16'(e.g));
          winCnt++;
          if (winCnt == NW) expDone = 1'b1;
        end
      end

      if (in_valid && in_ready) begin
        if (srcIdx >= NB) checkOutput("extra_beat", 1'b1, 1'b0);
        else srcIdx++;
      end

      prevStall = out_valid && !out_ready;
      prevTop   = out_top;
      prevMid   = out_mid;
      prevBot   = out_bot;
    end

    in_valid  = 1'b0;
    out_ready = 1'b0;
    start     = 1'b0;
    if (!wasReset) begin
      checkOutput("done_seen", sawDone, 1'b1);
      checkOutput("win_count", winCnt, NW);
      @(negedge clk);
      checkOutput("done_once", done, 1'b0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_in_ready", in_ready, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_out_y", out_y, 16'd0);
    checkOutput("reset_out_mid", out_mid, '0);
    rst = 1'b0;

    $display("[TB] directed frame with backpressure");
    applyStimulus(1'b1, 0, 1'b0);
    $display("[TB] second directed frame");
    applyStimulus(1'b1, 0, 1'b0);
    $display("[TB] reset after 5 beats, then full frame");
    applyStimulus(1'b0, 5, 1'b0);
    applyStimulus(1'b1, 0, 1'b0);
    $display("[TB] start pulsed during streaming");
    applyStimulus(1'b1, 0, 1'b1);
    $display("[TB] random frames");
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 0, i[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
